// File: rtl/cs_window_filter.sv
// cs_window_filter: sliding-window sum/average filter with approximate-value output, handshakes and saturation
module cs_window_filter #(
  parameter int DW    = 8,
  parameter int DEPTH = 9,
  parameter int SHIFT = 3,
  parameter int OW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_sat
);
  localparam int SUMW = $clog2(DEPTH * (2**DW - 1) + 1);
  localparam int YW   = (SUMW > OW ? SUMW : OW) + 1;
  localparam int FW   = $clog2(DEPTH + 1);

  logic [DW-1:0]   r_win [DEPTH];
  logic [SUMW-1:0] r_sum;
  logic [FW-1:0]   r_fill;
  logic            r_out_valid;
  logic [OW-1:0]   r_out_data;
  logic            r_out_sat;

  logic            w_accept;
  logic [SUMW-1:0] w_sum_nxt;
  logic [DW-1:0]   w_avg;
  logic [DW-1:0]   w_xmax;
  logic [DW-1:0]   w_x;
  logic [YW-1:0]   w_y;
  logic            w_sat;

  assign in_ready  = !r_out_valid | out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign w_accept  = in_valid & in_ready;
  assign w_sum_nxt = r_sum - SUMW'(r_win[DEPTH-1]) + SUMW'(in_data);
  assign w_avg     = DW'(w_sum_nxt / SUMW'(DEPTH));
  assign w_x       = mode ? w_avg : w_xmax;
  assign w_y       = (YW'(DEPTH) * YW'(w_x) + YW'(w_sum_nxt)) >> SHIFT;
  assign w_sat     = w_y > YW'(2**OW - 1);

  // largest post-accept window sample not above the average; the window minimum always qualifies
  always_comb begin
    w_xmax = (in_data <= w_avg) ? in_data : '0;
    for (int k = 0; k < DEPTH - 1; k++)
      w_xmax = (r_win[k] <= w_avg && r_win[k] > w_xmax) ? r_win[k] : w_xmax;
  end

  // window shift, running sum, fill tracking and the single-entry output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win       <= '{default: '0};
      r_sum       <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (flush) begin
      r_win       <= '{default: '0};
      r_sum       <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_win[0] <= in_data;
        for (int k = DEPTH - 1; k > 0; k--) r_win[k] <= r_win[k-1];
        r_sum  <= w_sum_nxt;
        r_fill <= (r_fill == FW'(DEPTH)) ? r_fill : r_fill + 1'b1;
      end
      if (w_accept && r_fill >= FW'(DEPTH - 1)) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sat ? '1 : w_y[OW-1:0];
        r_out_sat   <= w_sat;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cs_window_filter.sv
// tb_cs_window_filter: randomized and directed checks of cs_window_filter against a queue-based model
module tb_cs_window_filter;
  localparam int DEPTH = 9;
  localparam int SHIFT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b1;
  logic       in_ready0, out_valid0, out_sat0;
  logic [9:0] out_data0;
  logic       in_ready1, out_valid1, out_sat1;
  logic [8:0] out_data1;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;

  int  q[$];
  bit  exp_ov = 1'b0;
  int  exp_d0 = 0, exp_d1 = 0;
  bit  exp_s0 = 1'b0, exp_s1 = 1'b0;
  int  m_sum, m_avg, m_x, m_raw;

  cs_window_filter #(.DW(8), .DEPTH(DEPTH), .SHIFT(SHIFT), .OW(10)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0));

  cs_window_filter #(.DW(8), .DEPTH(DEPTH), .SHIFT(SHIFT), .OW(9)) u_sat (
    .clk(clk), .reset(reset), .flush(flush), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1));

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: queue of accepted samples, newest first; outputs recomputed from the whole window
  always @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      q.delete();
      exp_ov = 1'b0; exp_d0 = 0; exp_d1 = 0; exp_s0 = 1'b0; exp_s1 = 1'b0;
    end else if (in_valid && (!exp_ov || out_ready)) begin
      q.push_front(int'(in_data));
      if (q.size() > DEPTH) void'(q.pop_back());
      if (q.size() == DEPTH) begin
        m_sum = 0;
        foreach (q[i]) m_sum += q[i];
        m_avg = m_sum / DEPTH;
        m_x = 0;
        foreach (q[i]) if (q[i] <= m_avg && q[i] > m_x) m_x = q[i];
        if (mode) m_x = m_avg;
        m_raw = (DEPTH * m_x + m_sum) >> SHIFT;
        exp_ov = 1'b1;
        exp_s0 = m_raw > 1023; exp_d0 = exp_s0 ? 1023 : m_raw;
        exp_s1 = m_raw > 511;  exp_d1 = exp_s1 ? 511 : m_raw;
      end else if (out_ready) exp_ov = 1'b0;
    end else if (out_ready) exp_ov = 1'b0;
  end

  // every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("in_ready",   int'(in_ready0),  int'(!exp_ov || out_ready));
      cmp("out_valid",  int'(out_valid0), int'(exp_ov));
      cmp("out_data",   int'(out_data0),  exp_d0);
      cmp("out_sat",    int'(out_sat0),   int'(exp_s0));
      cmp("ow9_valid",  int'(out_valid1), int'(exp_ov));
      cmp("ow9_data",   int'(out_data1),  exp_d1);
      cmp("ow9_sat",    int'(out_sat1),   int'(exp_s1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d);
    in_valid = 1'b1;
    in_data = 8'(d);
    for (int i = 0; i < 20 && !in_ready0; i++) step();
    if (!in_ready0) cmp("push_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  int held;

  initial begin
    step();
    step();
    chk_en = 1'b1;
    cmp("rst_valid", int'(out_valid0), 0);
    cmp("rst_data",  int'(out_data0), 0);
    cmp("rst_sat",   int'(out_sat0), 0);
    reset = 1'b1;
    step();
    repeat (8) push(10);
    cmp("t1_no_out", int'(out_valid0), 0);
    push(10);
    cmp("t1_valid", int'(out_valid0), 1);
    cmp("t1_data",  int'(out_data0), 22);
    cmp("t1_sat",   int'(out_sat0), 0);
    cmp("t1_model", exp_d0, 22);
    push(19);
    cmp("t2_data", int'(out_data0), 23);
    do_flush();
    repeat (8) push(0);
    push(90);
    cmp("t3_mode0", int'(out_data0), 11);
    do_flush();
    repeat (8) push(0);
    mode = 1'b1;
    push(90);
    cmp("t3_mode1", int'(out_data0), 22);
    mode = 1'b0;
    do_flush();
    repeat (9) push(255);
    out_ready = 1'b0;
    cmp("t4_d10",  int'(out_data0), 573);
    cmp("t4_s10",  int'(out_sat0), 0);
    cmp("t4_d9",   int'(out_data1), 511);
    cmp("t4_s9",   int'(out_sat1), 1);
    in_valid = 1'b1;
    in_data = 8'd77;
    held = int'(out_data0);
    repeat (5) begin
      step();
      cmp("t5_ready_low", int'(in_ready0), 0);
      cmp("t5_hold", int'(out_data0), held);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    cmp("t5_valid", int'(out_valid0), 1);
    cmp("t5_data",  int'(out_data0), 351);
    repeat (5) push($urandom_range(0, 255));
    cmp("t6_pre_valid", int'(out_valid0), 1);
    reset = 1'b0;
    #1;
    cmp("t6_rst_valid", int'(out_valid0), 0);
    cmp("t6_rst_data",  int'(out_data0), 0);
    cmp("t6_rst_sat",   int'(out_sat0), 0);
    step();
    reset = 1'b1;
    step();
    repeat (8) push(40);
    cmp("t6_no_out", int'(out_valid0), 0);
    push(40);
    cmp("t6_valid", int'(out_valid0), 1);
    cmp("t6_data",  int'(out_data0), 90);
    repeat (5) push(1);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd200;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    cmp("t6_fl_valid", int'(out_valid0), 0);
    cmp("t6_fl_data",  int'(out_data0), 0);
    repeat (8) push(50);
    cmp("t6_fl_no_out", int'(out_valid0), 0);
    push(50);
    cmp("t6_fl_valid2", int'(out_valid0), 1);
    cmp("t6_fl_data2",  int'(out_data0), 112);
    repeat (3000) begin
      int r;
      r = int'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = (r == 0) ? 8'd0 : (r < 3) ? 8'd255 : 8'($urandom_range(0, 255));
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 59) == 0);
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
